// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm
// Multi-cycle sequencer for an RV32I datapath subset (LUI, R-type, I-arith,
// LW, SW, branches, JAL, JALR). Each instruction walks FETCH -> DECODE ->
// EXEC [-> MEM] [-> WB] over a single shared memory port whose latency is
// variable. Per-state enables drive the PC, IR, register file and memory.
// Retired instructions are counted. The controller halts in TRAP on an
// illegal opcode or on a memory request left unanswered for too long.
//
// Parameters
//   TIMEOUT    consecutive unanswered request cycles that raise a timeout (>= 2)
//   CNT_W      width of the retired-instruction counter
//
// Ports
//   clk        rising-edge clock
//   rstn       synchronous reset, active low
//   run        start/continue fetching, looked at only in FETCH
//   op         IR[6:0]
//   funct3     IR[14:12]
//   zero       branch condition from the ALU, 1 = taken
//   mem_ready  memory finishes the outstanding request this cycle
//   mem_req    memory request valid
//   mem_we     request is a write
//   addr_sel   memory address source: 0 = PC, 1 = ALU result
//   ir_we      load the instruction register
//   reg_we     register file write
//   wd_sel     write data: 00 = ALU, 01 = memory, 10 = PC+4
//   pc_we      PC update (also marks a retired instruction)
//   npc_op     next PC: 000 = +4, 001 = branch, 010 = jal, 100 = jalr
//   state      0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 TRAP
//   trap       controller halted in TRAP
//   trap_cause 01 = illegal instruction, 10 = memory timeout, 00 = none
//   instr_cnt  retired-instruction count, wraps
module mc_ctrl_fsm #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             reg_we,
  output logic [1:0]       wd_sel,
  output logic             pc_we,
  output logic [2:0]       npc_op,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instr_cnt
);

  // Wide enough to hold TIMEOUT itself, so the increment never overflows.
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_LUI  = 4'd0,
    CL_R    = 4'd1,
    CL_I    = 4'd2,
    CL_LW   = 4'd3,
    CL_SW   = 4'd4,
    CL_BR   = 4'd5,
    CL_JAL  = 4'd6,
    CL_JALR = 4'd7,
    CL_ILL  = 4'd8
  } iclass_t;

  // Map opcode/funct3 onto the supported instruction classes.
  function automatic iclass_t classify(input logic [6:0] op_v, input logic [2:0] f3_v);
    iclass_t c;
    case (op_v)
      7'b0110111: c = CL_LUI;
      7'b0110011: c = CL_R;
      7'b0010011: c = CL_I;
      7'b0000011: begin
        if (f3_v == 3'b010) c = CL_LW;
        else                c = CL_ILL;
      end
      7'b0100011: begin
        if (f3_v == 3'b010) c = CL_SW;
        else                c = CL_ILL;
      end
      7'b1100011: c = CL_BR;
      7'b1101111: c = CL_JAL;
      7'b1100111: begin
        if (f3_v == 3'b000) c = CL_JALR;
        else                c = CL_ILL;
      end
      default:    c = CL_ILL;
    endcase
    return c;
  endfunction

  state_t           state_r;
  state_t           next_state_s;
  iclass_t          class_r;
  iclass_t          class_next_s;
  iclass_t          dec_class_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_next_s;
  logic [WAIT_W-1:0] wait_inc_s;
  logic [1:0]       cause_r;
  logic [1:0]       cause_next_s;
  logic [CNT_W-1:0] cnt_r;

  logic             mem_req_s;
  logic             mem_we_s;
  logic             addr_sel_s;
  logic             ir_we_s;
  logic             reg_we_s;
  logic [1:0]       wd_sel_s;
  logic             pc_we_s;
  logic [2:0]       npc_op_s;
  logic             trap_s;

  assign dec_class_s = classify(op, funct3);
  assign wait_inc_s  = wait_cnt_r + WAIT_W'(1);

  // Next-state, bookkeeping and raw enable decode for the current state.
  always_comb begin
    next_state_s = state_r;
    class_next_s = class_r;
    cause_next_s = cause_r;
    // The wait counter clears unless a stalled request explicitly extends it.
    wait_next_s  = '0;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    addr_sel_s   = 1'b0;
    ir_we_s      = 1'b0;
    reg_we_s     = 1'b0;
    wd_sel_s     = 2'b00;
    pc_we_s      = 1'b0;
    npc_op_s     = 3'b000;
    trap_s       = 1'b0;

    case (state_r)
      ST_FETCH: begin
        if (run) begin
          mem_req_s = 1'b1;
          if (mem_ready) begin
            // A completion on the last allowed cycle still counts.
            ir_we_s      = 1'b1;
            next_state_s = ST_DECODE;
          end else if (wait_inc_s == WAIT_LIMIT) begin
            cause_next_s = 2'b10;
            next_state_s = ST_TRAP;
          end else begin
            wait_next_s = wait_inc_s;
          end
        end else begin
          next_state_s = ST_FETCH;
        end
      end

      ST_DECODE: begin
        class_next_s = dec_class_s;
        if (dec_class_s == CL_ILL) begin
          cause_next_s = 2'b01;
          next_state_s = ST_TRAP;
        end else begin
          next_state_s = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (class_r)
          CL_LUI, CL_R, CL_I: next_state_s = ST_WB;
          CL_LW, CL_SW:       next_state_s = ST_MEM;
          CL_BR: begin
            pc_we_s = 1'b1;
            if (zero) npc_op_s = 3'b001;
            else      npc_op_s = 3'b000;
            next_state_s = ST_FETCH;
          end
          CL_JAL: begin
            reg_we_s     = 1'b1;
            wd_sel_s     = 2'b10;
            pc_we_s      = 1'b1;
            npc_op_s     = 3'b010;
            next_state_s = ST_FETCH;
          end
          CL_JALR: begin
            reg_we_s     = 1'b1;
            wd_sel_s     = 2'b10;
            pc_we_s      = 1'b1;
            npc_op_s     = 3'b100;
            next_state_s = ST_FETCH;
          end
          default: begin
            // A corrupted class register is treated as an illegal instruction.
            cause_next_s = 2'b01;
            next_state_s = ST_TRAP;
          end
        endcase
      end

      ST_MEM: begin
        mem_req_s  = 1'b1;
        addr_sel_s = 1'b1;
        mem_we_s   = (class_r == CL_SW);
        if (mem_ready) begin
          if (class_r == CL_SW) begin
            pc_we_s      = 1'b1;
            npc_op_s     = 3'b000;
            next_state_s = ST_FETCH;
          end else begin
            next_state_s = ST_WB;
          end
        end else if (wait_inc_s == WAIT_LIMIT) begin
          cause_next_s = 2'b10;
          next_state_s = ST_TRAP;
        end else begin
          wait_next_s = wait_inc_s;
        end
      end

      ST_WB: begin
        reg_we_s = 1'b1;
        if (class_r == CL_LW) wd_sel_s = 2'b01;
        else                  wd_sel_s = 2'b00;
        pc_we_s      = 1'b1;
        npc_op_s     = 3'b000;
        next_state_s = ST_FETCH;
      end

      ST_TRAP: begin
        trap_s       = 1'b1;
        next_state_s = ST_TRAP;
      end

      default: begin
        // Unreachable encodings park the controller.
        next_state_s = ST_TRAP;
      end
    endcase
  end

  // State, class, wait counter, trap cause and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r    <= ST_FETCH;
      class_r    <= CL_ILL;
      wait_cnt_r <= '0;
      cause_r    <= 2'b00;
      cnt_r      <= '0;
    end else begin
      state_r    <= next_state_s;
      class_r    <= class_next_s;
      wait_cnt_r <= wait_next_s;
      cause_r    <= cause_next_s;
      if (pc_we_s) cnt_r <= cnt_r + CNT_W'(1);
      else         cnt_r <= cnt_r;
    end
  end

  // Enables are held low while reset is asserted so an aborted
  // instruction cannot write anything on the reset edge.
  assign mem_req    = rstn & mem_req_s;
  assign mem_we     = rstn & mem_we_s;
  assign addr_sel   = rstn & addr_sel_s;
  assign ir_we      = rstn & ir_we_s;
  assign reg_we     = rstn & reg_we_s;
  assign wd_sel     = rstn ? wd_sel_s : 2'b00;
  assign pc_we      = rstn & pc_we_s;
  assign npc_op     = rstn ? npc_op_s : 3'b000;
  assign trap       = rstn & trap_s;
  assign state      = state_r;
  assign trap_cause = cause_r;
  assign instr_cnt  = cnt_r;

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle sequencer for the RV32I datapath subset: LUI, R-type, I-arith, LW, SW, branches, JAL, JALR.
- Replaces single-cycle timing with FETCH/DECODE/EXEC/MEM/WB states over one shared, variable-latency memory port.
- Generates per-state enables for the PC, IR, register file and memory.
- Tracks retired instructions and traps on illegal opcodes or a memory timeout.

Parameters:
- TIMEOUT, 16, consecutive unanswered memory-request cycles before a timeout trap (≥2).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  synchronous reset, active low.
- run  in  1  start/continue fetching; sampled only in FETCH.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- zero  in  1  ALU branch-condition result; 1 = branch taken.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  request is a write.
- addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result.
- ir_we  out  1  load IR.
- reg_we  out  1  register file write.
- wd_sel  out  2  write-data select: 00 = ALU, 01 = MEM, 10 = PC+4.
- pc_we  out  1  PC update.
- npc_op  out  3  next-PC select: 000 = +4, 001 = branch, 010 = jal, 100 = jalr.
- state  out  3  current state: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 TRAP.
- trap  out  1  controller halted in TRAP.
- trap_cause  out  2  01 = illegal instruction, 10 = memory timeout, 00 = none.
- instr_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Registered: state, wait_cnt, instr_cnt, trap_cause, latched instruction class (captured in DECODE).
- All other outputs are combinational from state, class and inputs, and forced to 0 while rstn = 0.
- Reset (rstn low at a clock edge): state = FETCH, instr_cnt = 0, wait_cnt = 0, trap_cause = 00. Reset mid-instruction aborts with no further writes.
- FETCH:
  - run = 0: no request; stay in FETCH.
  - run = 1: mem_req = 1, addr_sel = 0. On mem_ready: ir_we = 1, go to DECODE.
- DECODE: classify op.
  - Legal classes: 0110111 LUI, 0110011 R, 0010011 I, 0000011 with funct3 = 010, 0100011 with funct3 = 010, 1100011 branch, 1101111 JAL, 1100111 with funct3 = 000.
  - Anything else: trap_cause = 01, go to TRAP.
  - Legal: go to EXEC. No enables asserted in DECODE.
- EXEC:
  - LUI/R/I: go to WB.
  - LW/SW: go to MEM.
  - Branch: pc_we = 1, npc_op = 001 if zero else 000; go to FETCH.
  - JAL/JALR: reg_we = 1, wd_sel = 10, pc_we = 1, npc_op = 010 or 100; go to FETCH.
- MEM: mem_req = 1, addr_sel = 1, mem_we = 1 for SW. On mem_ready:
  - SW: pc_we = 1, npc_op = 000; go to FETCH.
  - LW: go to WB.
- WB: reg_we = 1, wd_sel = 01 for LW else 00, pc_we = 1, npc_op = 000; go to FETCH.
- TRAP: all enables 0, trap = 1; sticky until reset.
- instr_cnt: +1 on every cycle with pc_we = 1; wraps modulo 2^CNT_W.
- wait_cnt:
  - Increments each FETCH/MEM cycle with mem_req = 1 and mem_ready = 0.
  - Clears on any state change and on FETCH cycles with run = 0.
  - If the cycle would make wait_cnt reach TIMEOUT (mem_ready = 0): trap_cause = 10, go to TRAP.
  - mem_ready in that same cycle wins; normal completion.
- run dropped mid-instruction: the instruction completes; the controller idles at the next FETCH.
- Minimum latency with mem_ready held high: branch/JAL/JALR 3 cycles, ALU/LUI/SW 4, LW 5.

Test Plan:
- add (op 0110011), mem_ready = 1, run = 1 → states 0,1,2,4,0; reg_we and pc_we in cycle 4 only, wd_sel = 00; instr_cnt = 1.
- lw (op 0000011, funct3 010), mem_ready low 3 cycles in MEM → mem_req/addr_sel = 1 for 4 MEM cycles; WB with wd_sel = 01; 8 cycles total.
- beq with zero = 1, then zero = 0 → EXEC pc_we = 1, npc_op 001 then 000; reg_we never set; jal → reg_we = 1, wd_sel = 10, npc_op = 010.
- op = 1111111, or op 0000011 with funct3 = 000 → TRAP after DECODE, trap_cause = 01, trap stays 1 and instr_cnt frozen until rstn low.
- TIMEOUT = 4, mem_ready held 0 in FETCH → TRAP after 4 request cycles, trap_cause = 10; mem_ready on the 4th cycle → DECODE instead.
- rstn low during MEM of sw → no mem_we after the reset edge; state = 0, instr_cnt = 0. Then run = 0 → no mem_req issued.
